// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared constants and packet type for the 4-port switch
package packet_pkg;
   localparam int NUM_PORTS = 4;
   localparam int ID_W      = 4;
   localparam int DATA_W    = 8;

   typedef struct packed {
      logic [ID_W-1:0]   source;
      logic [ID_W-1:0]   target;
      logic [DATA_W-1:0] data;
   } packet_t;
endpackage

// File: rtl/port_if.sv
// rtl/port_if.sv - ingress/egress bundle between one port agent and the switch
interface port_if (
   input logic clk,
   input logic rst_n
);
   logic       valid_in;
   logic [3:0] source_in;
   logic [3:0] target_in;
   logic [7:0] data_in;
   logic       valid_out;
   logic [3:0] source_out;
   logic [3:0] target_out;
   logic [7:0] data_out;

   modport switch (
      input  clk, rst_n, valid_in, source_in, target_in, data_in,
      output valid_out, source_out, target_out, data_out
   );

   modport agent (
      input  clk, rst_n, valid_out, source_out, target_out, data_out,
      output valid_in, source_in, target_in, data_in
   );
endinterface

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - per-input packet FIFO, push accepted when full if a pop happens too
module port_fifo
   import packet_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  packet_t push_pkt,
   input  logic    pop,
   output logic    empty,
   output packet_t head
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   packet_t          mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         mem[wr_ptr] <= push_pkt;
      end
   end

   // Pointers and occupancy; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/switch_4port.sv
// rtl/switch_4port.sv - 4-port single-beat switch with all-or-nothing multicast arbitration
module switch_4port
   import packet_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   port_if.switch port0,
   port_if.switch port1,
   port_if.switch port2,
   port_if.switch port3
);
   logic [NUM_PORTS-1:0] vin;
   logic [ID_W-1:0]      sin [NUM_PORTS];
   logic [ID_W-1:0]      tin [NUM_PORTS];
   logic [DATA_W-1:0]    din [NUM_PORTS];

   logic [NUM_PORTS-1:0] push;
   packet_t              push_pkt [NUM_PORTS];
   logic [NUM_PORTS-1:0] empty;
   packet_t              head [NUM_PORTS];

   logic [NUM_PORTS-1:0] grant;
   logic [ID_W-1:0]      claimed;
   logic                 any_grant;
   logic [1:0]           first_idx;
   logic [1:0]           idx;
   logic [1:0]           rr;

   logic [NUM_PORTS-1:0] out_valid;
   packet_t              out_pkt [NUM_PORTS];
   logic [NUM_PORTS-1:0] valid_q;
   packet_t              pkt_q [NUM_PORTS];

   assign vin[0] = port0.valid_in;  assign sin[0] = port0.source_in;
   assign tin[0] = port0.target_in; assign din[0] = port0.data_in;
   assign vin[1] = port1.valid_in;  assign sin[1] = port1.source_in;
   assign tin[1] = port1.target_in; assign din[1] = port1.data_in;
   assign vin[2] = port2.valid_in;  assign sin[2] = port2.source_in;
   assign tin[2] = port2.target_in; assign din[2] = port2.data_in;
   assign vin[3] = port3.valid_in;  assign sin[3] = port3.source_in;
   assign tin[3] = port3.target_in; assign din[3] = port3.data_in;

   // Ingress: strip loopback bit, drop packets with no remaining target.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
      assign push_pkt[g].source = sin[g];
      assign push_pkt[g].target = tin[g] & ~(ID_W'(1) << g);
      assign push_pkt[g].data   = din[g];
      assign push[g]            = vin[g] && (push_pkt[g].target != '0);

      port_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[g]),
         .push_pkt (push_pkt[g]),
         .pop      (grant[g]),
         .empty    (empty[g]),
         .head     (head[g])
      );
   end

   // Round-robin scan from rr; grant heads whose whole mask is still unclaimed.
   always_comb begin
      grant     = '0;
      claimed   = '0;
      any_grant = 1'b0;
      first_idx = rr;
      idx       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = rr + 2'(i);
         if (!empty[idx] && ((head[idx].target & claimed) == '0)) begin
            grant[idx] = 1'b1;
            claimed    = claimed | head[idx].target;
            if (!any_grant) begin
               first_idx = idx;
               any_grant = 1'b1;
            end
         end
      end
   end

   // Crossbar: granted masks are disjoint, so each output has at most one source.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         out_valid[o] = 1'b0;
         out_pkt[o]   = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i] && head[i].target[o]) begin
               out_valid[o] = 1'b1;
               out_pkt[o]   = head[i];
            end
         end
      end
   end

   // Registered egress and round-robin pointer advance past the first winner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            valid_q[o] <= 1'b0;
            pkt_q[o]   <= '0;
         end
      end else begin
         if (any_grant) rr <= first_idx + 2'd1;
         for (int o = 0; o < NUM_PORTS; o++) begin
            valid_q[o] <= out_valid[o];
            pkt_q[o]   <= out_pkt[o];
         end
      end
   end

   assign port0.valid_out  = valid_q[0];
   assign port0.source_out = pkt_q[0].source;
   assign port0.target_out = pkt_q[0].target;
   assign port0.data_out   = pkt_q[0].data;
   assign port1.valid_out  = valid_q[1];
   assign port1.source_out = pkt_q[1].source;
   assign port1.target_out = pkt_q[1].target;
   assign port1.data_out   = pkt_q[1].data;
   assign port2.valid_out  = valid_q[2];
   assign port2.source_out = pkt_q[2].source;
   assign port2.target_out = pkt_q[2].target;
   assign port2.data_out   = pkt_q[2].data;
   assign port3.valid_out  = valid_q[3];
   assign port3.source_out = pkt_q[3].source;
   assign port3.target_out = pkt_q[3].target;
   assign port3.data_out   = pkt_q[3].data;
endmodule

// File: tb/tb_switch_4port.sv
// tb/tb_switch_4port.sv - scoreboard bench with queue-based reference model for switch_4port
module tb_switch_4port;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0] src;
      logic [3:0] tgt;
      logic [7:0] data;
   } mpkt_t;

   typedef struct {
      int         cyc;
      logic [3:0] src;
      logic [3:0] tgt;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] vin = '0;
   logic [3:0] sin [4];
   logic [3:0] tin [4];
   logic [7:0] din [4];
   logic [3:0] vout;
   logic [3:0] sout [4];
   logic [3:0] tout [4];
   logic [7:0] dout [4];

   port_if p0 (clk, rst_n);
   port_if p1 (clk, rst_n);
   port_if p2 (clk, rst_n);
   port_if p3 (clk, rst_n);

   switch_4port #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .port0 (p0),
      .port1 (p1),
      .port2 (p2),
      .port3 (p3)
   );

   assign p0.valid_in = vin[0]; assign p0.source_in = sin[0]; assign p0.target_in = tin[0]; assign p0.data_in = din[0];
   assign p1.valid_in = vin[1]; assign p1.source_in = sin[1]; assign p1.target_in = tin[1]; assign p1.data_in = din[1];
   assign p2.valid_in = vin[2]; assign p2.source_in = sin[2]; assign p2.target_in = tin[2]; assign p2.data_in = din[2];
   assign p3.valid_in = vin[3]; assign p3.source_in = sin[3]; assign p3.target_in = tin[3]; assign p3.data_in = din[3];
   assign vout[0] = p0.valid_out; assign sout[0] = p0.source_out; assign tout[0] = p0.target_out; assign dout[0] = p0.data_out;
   assign vout[1] = p1.valid_out; assign sout[1] = p1.source_out; assign tout[1] = p1.target_out; assign dout[1] = p1.data_out;
   assign vout[2] = p2.valid_out; assign sout[2] = p2.source_out; assign tout[2] = p2.target_out; assign dout[2] = p2.data_out;
   assign vout[3] = p3.valid_out; assign sout[3] = p3.source_out; assign tout[3] = p3.target_out; assign dout[3] = p3.data_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mpkt_t mq [4][$];
   exp_t  eq [4][$];
   int    rr_m = 0;

   // Reference model: per-input packet queues, arbitration on contents before the edge.
   int         m_first;
   int         m_i;
   logic [3:0] m_claimed;
   logic [3:0] m_grant;
   logic [3:0] m_mask;
   mpkt_t      m_pkt;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         for (int p = 0; p < 4; p++) mq[p].delete();
         rr_m = 0;
      end else begin
         m_claimed = '0;
         m_grant   = '0;
         m_first   = -1;
         for (int k = 0; k < 4; k++) begin
            m_i = (rr_m + k) % 4;
            if (mq[m_i].size() > 0 && (mq[m_i][0].tgt & m_claimed) == 4'd0) begin
               m_pkt       = mq[m_i][0];
               m_claimed   = m_claimed | m_pkt.tgt;
               m_grant[m_i] = 1'b1;
               if (m_first < 0) m_first = m_i;
               for (int o = 0; o < 4; o++)
                  if (m_pkt.tgt[o]) eq[o].push_back('{cyc, m_pkt.src, m_pkt.tgt, m_pkt.data});
            end
         end
         if (m_first >= 0) rr_m = (m_first + 1) % 4;
         for (int p = 0; p < 4; p++)
            if (m_grant[p]) void'(mq[p].pop_front());
         for (int p = 0; p < 4; p++) begin
            if (vin[p]) begin
               m_mask = tin[p] & ~(4'b0001 << p);
               if (m_mask != 4'd0 && mq[p].size() < DEPTH)
                  mq[p].push_back('{sin[p], m_mask, din[p]});
            end
         end
      end
   end

   // Monitor: compare each egress beat against the expected queue for that port.
   exp_t e;
   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int o = 0; o < 4; o++) begin
            while (eq[o].size() > 0 && eq[o][0].cyc < cyc) begin
               e = eq[o].pop_front();
               checks++; errors++;
               $display("FAIL missed_delivery port%0d cyc %0d: got nothing, required data %h src %b tgt %b at cyc %0d",
                        o, cyc, e.data, e.src, e.tgt, e.cyc);
            end
            checks++;
            if (vout[o]) begin
               if (eq[o].size() == 0 || eq[o][0].cyc != cyc) begin
                  errors++;
                  $display("FAIL unexpected_delivery port%0d cyc %0d: got data %h src %b tgt %b, required no valid_out",
                           o, cyc, dout[o], sout[o], tout[o]);
               end else begin
                  e = eq[o].pop_front();
                  if (sout[o] !== e.src || tout[o] !== e.tgt || dout[o] !== e.data) begin
                     errors++;
                     $display("FAIL packet_content port%0d cyc %0d: got src %b tgt %b data %h, required src %b tgt %b data %h",
                              o, cyc, sout[o], tout[o], dout[o], e.src, e.tgt, e.data);
                  end
               end
            end else if (vout[o] !== 1'b0 || sout[o] !== 4'd0 || tout[o] !== 4'd0 || dout[o] !== 8'd0) begin
               errors++;
               $display("FAIL idle_outputs port%0d cyc %0d: got valid %b src %b tgt %b data %h, required all 0",
                        o, cyc, vout[o], sout[o], tout[o], dout[o]);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] v, input logic [15:0] tg, input logic [31:0] d);
      for (int p = 0; p < 4; p++) begin
         vin[p] = v[p];
         tin[p] = tg[p*4 +: 4];
         din[p] = d[p*8 +: 8];
      end
      @(posedge clk); #1;
      vin = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      for (int p = 0; p < 4; p++) begin
         sin[p] = 4'b0001 << p;
         tin[p] = '0;
         din[p] = '0;
      end
      // Reset held for 5 edges while every port pushes broadcasts.
      for (int k = 0; k < 5; k++) drive(4'b1111, 16'hFFFF, $urandom);
      rst_n = 1'b1;
      idle(2);
      // Multicast clash with rr=0: A0 then B0 to P2/P3.
      drive(4'b0011, 16'h00CC, 32'h0000B0A0);
      idle(4);
      // Broadcast from P2 versus unicast from P3 (rr is now 2).
      drive(4'b1100, 16'h1F00, 32'h33FF0000);
      idle(4);
      // Disjoint parallel grants.
      drive(4'b0101, 16'h0802, 32'h00220011);
      idle(3);
      // Chained contention, then a follow-up from P1 two edges later.
      drive(4'b1010, 16'hF0C0, 32'hEE00DD00);
      idle(1);
      drive(4'b0010, 16'h0050, 32'h0000CC00);
      idle(10);
      // Self-only target is discarded.
      drive(4'b0010, 16'h0020, 32'h00007700);
      idle(3);
      // Overflow P0 while P3 broadcasts compete for P1.
      for (int k = 0; k <= DEPTH; k++)
         drive(4'b1001, 16'hF002, {8'h80 + 8'(k), 16'h0000, 8'h01 + 8'(k)});
      idle(15);
      // Randomized traffic with a mid-operation reset.
      for (int k = 0; k < 400; k++) begin
         if (k == 200) rst_n = 1'b0;
         if (k == 202) rst_n = 1'b1;
         drive(4'($urandom), 16'($urandom), $urandom);
      end
      idle(25);
      for (int o = 0; o < 4; o++) begin
         checks++;
         if (eq[o].size() != 0) begin
            errors++;
            $display("FAIL drain_expected port%0d: got %0d undelivered, required 0", o, eq[o].size());
         end
         checks++;
         if (mq[o].size() != 0) begin
            errors++;
            $display("FAIL drain_model input%0d: got %0d queued, required 0", o, mq[o].size());
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
